// File: rtl/vga_pkg.sv
// 640x480@60 VGA raster constants and the per-axis phase type shared by the timing generator.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef enum logic [1:0] {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK} vga_phase_e;

endpackage

// File: rtl/vga_axis_timer.sv
// One raster axis: a counter walking ACTIVE -> FRONT -> SYNC -> BACK and wrapping after BACK.
// phase_next is exposed so the parent can register decoded levels on the same edge as count.
module vga_axis_timer
  import vga_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE,
  parameter int FRONT  = H_FP,
  parameter int SYNC   = H_SYNC,
  parameter int BACK   = H_BP,
  parameter int CW     = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          advance,
  output logic [CW-1:0] count,
  output vga_phase_e    phase_next,
  output logic          wrap
);

  localparam logic [CW-1:0] END_ACTIVE = CW'(ACTIVE - 1);
  localparam logic [CW-1:0] END_FRONT  = CW'(ACTIVE + FRONT - 1);
  localparam logic [CW-1:0] END_SYNC   = CW'(ACTIVE + FRONT + SYNC - 1);
  localparam logic [CW-1:0] END_BACK   = CW'(ACTIVE + FRONT + SYNC + BACK - 1);

  vga_phase_e    phase;
  logic [CW-1:0] count_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      phase <= PH_ACTIVE;
    end else begin
      count <= count_next;
      phase <= phase_next;
    end
  end

  always_comb begin
    count_next = count;
    phase_next = phase;
    wrap       = 1'b0;
    if (advance) begin
      count_next = count + 1'b1;
      case (phase)
        PH_ACTIVE: if (count == END_ACTIVE) phase_next = PH_FRONT;
        PH_FRONT:  if (count == END_FRONT)  phase_next = PH_SYNC;
        PH_SYNC:   if (count == END_SYNC)   phase_next = PH_BACK;
        PH_BACK: begin
          if (count == END_BACK) begin
            count_next = '0;
            phase_next = PH_ACTIVE;
            wrap       = 1'b1;
          end
        end
        default: begin
          count_next = '0;
          phase_next = PH_ACTIVE;
        end
      endcase
      // A count beyond the axis length can only come from corrupted state; restart the axis.
      if (count > END_BACK) begin
        count_next = '0;
        phase_next = PH_ACTIVE;
      end
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel CE divider, h/v axis timers and aligned registered outputs.
// Define VGA_FRAME_CNT_EN to build the free-running frame counter behind o_frame_cnt.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV      = 2,
  parameter int FRAME_CNT_W  = 8,
  parameter int H_ACTIVE_LEN = H_ACTIVE,
  parameter int H_FP_LEN     = H_FP,
  parameter int H_SYNC_LEN   = H_SYNC,
  parameter int H_BP_LEN     = H_BP,
  parameter int V_ACTIVE_LEN = V_ACTIVE,
  parameter int V_FP_LEN     = V_FP,
  parameter int V_SYNC_LEN   = V_SYNC,
  parameter int V_BP_LEN     = V_BP
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  output logic                   o_pix_ce,
  output logic [9:0]             o_x,
  output logic [9:0]             o_y,
  output logic                   o_de,
  output logic                   o_hsync,
  output logic                   o_vsync,
  output logic                   o_blank_n,
  output logic                   o_frame_start,
  output logic [FRAME_CNT_W-1:0] o_frame_cnt
);

  localparam int              DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_reg;
  logic [DW-1:0] div_next;
  logic          pix_ce_reg;
  logic          hsync_reg;
  logic          vsync_reg;
  logic          de_reg;
  logic          frame_start_reg;
  logic          h_wrap;
  logic          v_wrap;
  vga_phase_e    h_phase_next;
  vga_phase_e    v_phase_next;

  assign div_next = (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;

  // The strobe is registered so it stays low throughout reset even when CLK_DIV is 1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_reg    <= '0;
      pix_ce_reg <= 1'b0;
    end else begin
      div_reg    <= div_next;
      pix_ce_reg <= (div_next == DIV_LAST);
    end
  end

  vga_axis_timer #(
    .ACTIVE (H_ACTIVE_LEN),
    .FRONT  (H_FP_LEN),
    .SYNC   (H_SYNC_LEN),
    .BACK   (H_BP_LEN),
    .CW     (10)
  ) u_h_axis (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .advance    (pix_ce_reg),
    .count      (o_x),
    .phase_next (h_phase_next),
    .wrap       (h_wrap)
  );

  vga_axis_timer #(
    .ACTIVE (V_ACTIVE_LEN),
    .FRONT  (V_FP_LEN),
    .SYNC   (V_SYNC_LEN),
    .BACK   (V_BP_LEN),
    .CW     (10)
  ) u_v_axis (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .advance    (h_wrap),
    .count      (o_y),
    .phase_next (v_phase_next),
    .wrap       (v_wrap)
  );

  // Decoded levels load from the timers' next phase so they change on the same edge as o_x/o_y.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hsync_reg       <= 1'b1;
      vsync_reg       <= 1'b1;
      de_reg          <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      hsync_reg       <= (h_phase_next != PH_SYNC);
      vsync_reg       <= (v_phase_next != PH_SYNC);
      de_reg          <= (h_phase_next == PH_ACTIVE) && (v_phase_next == PH_ACTIVE);
      frame_start_reg <= v_wrap;
    end
  end

  assign o_pix_ce      = pix_ce_reg;
  assign o_hsync       = hsync_reg;
  assign o_vsync       = vsync_reg;
  assign o_de          = de_reg;
  assign o_blank_n     = de_reg;
  assign o_frame_start = frame_start_reg;

`ifdef VGA_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_cnt_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_cnt_reg <= '0;
    end else if (v_wrap) begin
      frame_cnt_reg <= frame_cnt_reg + 1'b1;
    end
  end

  assign o_frame_cnt = frame_cnt_reg;
`else
  assign o_frame_cnt = '0;
`endif

endmodule
